// File: rtl/cpu_mu0_delay1.sv
// MU0 accumulator CPU: 16-bit instructions from a 4096x16 RAM with one-cycle read latency.
// Latency: 2 cycles for STA/JMP/JGE/JNE/STP (and reserved opcodes), 3 cycles for LDA/ADD/SUB.
// Backpressure: none; sole bus master, memory always accepts a request in the cycle it is issued.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   running    high while executing, low once halted or in reset
//   address    12-bit memory word address
//   write      write strobe, RAM captures writedata at the next rising edge
//   read       read strobe, RAM returns readdata one cycle later
//   writedata  store data (always ACC)
//   readdata   memory read data
//
// Build option: define MU0_HALT_ON_ILLEGAL_EN to make opcodes 8-F halt like STP;
// otherwise they are 2-cycle no-ops.

module cpu_mu0_delay1 (
  input  logic        clk,
  input  logic        rst,
  output logic        running,
  output logic [11:0] address,
  output logic        write,
  output logic        read,
  output logic [15:0] writedata,
  input  logic [15:0] readdata
);

  typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALTED} state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  state_t      state;
  logic [11:0] pc;
  logic [15:0] acc;
  logic [3:0]  ir_op;   // opcode kept for EXEC2, when readdata carries the operand instead

  // Instruction fields are only meaningful during EXEC1.
  logic [3:0]  op;
  logic [11:0] opnd;
  logic        jump_taken;
  logic        is_mem_rd;
  logic        is_halt;

  assign op   = readdata[15:12];
  assign opnd = readdata[11:0];

  assign is_mem_rd = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);

`ifdef MU0_HALT_ON_ILLEGAL_EN
  assign is_halt = (op == OP_STP) || op[3];
`else
  assign is_halt = (op == OP_STP);
`endif

  always_comb begin
    jump_taken = 1'b0;
    case (op)
      OP_JMP:  jump_taken = 1'b1;
      OP_JGE:  jump_taken = !acc[15];        // zero counts as non-negative
      OP_JNE:  jump_taken = (acc != 16'h0000);
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      pc    <= 12'h000;
      acc   <= 16'h0000;
      ir_op <= 4'h0;
    end else begin
      case (state)
        FETCH: state <= EXEC1;
        EXEC1: begin
          ir_op <= op;
          pc    <= jump_taken ? opnd : pc + 12'd1;
          if (is_halt)        state <= HALTED;
          else if (is_mem_rd) state <= EXEC2;
          else                state <= FETCH;
        end
        EXEC2: begin
          case (ir_op)
            OP_LDA:  acc <= readdata;
            OP_ADD:  acc <= acc + readdata;
            OP_SUB:  acc <= acc - readdata;
            default: acc <= acc;
          endcase
          state <= FETCH;
        end
        default: state <= HALTED;
      endcase
    end
  end

  // Bus outputs depend on readdata in EXEC1, so they are decoded combinationally.
  // Gating with rst makes a mid-instruction reset drop any pending write at once.
  always_comb begin
    address = pc;
    read    = 1'b0;
    write   = 1'b0;
    if (!rst) begin
      address = 12'h000;
    end else begin
      case (state)
        FETCH: read = 1'b1;
        EXEC1: begin
          if (is_mem_rd) begin
            address = opnd;
            read    = 1'b1;
          end else if (op == OP_STA) begin
            address = opnd;
            write   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign writedata = rst ? acc : 16'h0000;
  assign running   = rst && (state != HALTED);

endmodule

// File: tb/tb_cpu_mu0_delay1.sv
// Self-checking bench for cpu_mu0_delay1 with a behavioural one-cycle-latency RAM.
// Latency: n/a.
// Backpressure: n/a.

module tb_cpu_mu0_delay1;

  logic        clk;
  logic        rst;
  logic        running;
  logic [11:0] address;
  logic        write;
  logic        read;
  logic [15:0] writedata;
  logic [15:0] readdata;

  logic [15:0] mem  [4096];
  logic [15:0] prog [4096];

  int n_chk = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int fetch1_cnt = 0;
  int clash_cnt = 0;

  cpu_mu0_delay1 dut (
    .clk       (clk),
    .rst       (rst),
    .running   (running),
    .address   (address),
    .write     (write),
    .read      (read),
    .writedata (writedata),
    .readdata  (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: reloaded from prog while reset is held, one-cycle read latency otherwise.
  always @(posedge clk) begin
    if (!rst) begin
      mem <= prog;
    end else begin
      if (write) mem[address] <= writedata;
      if (read)  readdata <= mem[address];
    end
  end

  always @(posedge clk) begin
    if (rst && write) wr_cnt++;
    if (rst && read && address == 12'h001) fetch1_cnt++;
    if (read && write) clash_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_begin();
    rst = 1'b0;
    for (int i = 0; i < 4096; i++) prog[i] = 16'h0000;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_rst();
    rst = 1'b1;
    #1;
  endtask

  task automatic run_to_halt(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(posedge clk);
      #1;
      n++;
      if (!running) break;
    end
  endtask

  int n;
  int wr0;
  int f0;

  initial begin
    rst = 1'b0;
    readdata = 16'h0000;

    // STP at address 0.
    load_begin();
    prog[0] = 16'h7000;
    settle();
    check("rst_running", running, 0);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_address", address, 0);
    check("rst_writedata", writedata, 0);
    wr0 = wr_cnt;
    release_rst();
    check("stp_running_after_release", running, 1);
    run_to_halt(50, n);
    check("stp_cycles", n, 2);
    check("stp_pc", dut.pc, 1);
    check("stp_no_writes", wr_cnt - wr0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("halted_stays", running, 0);
    check("halted_no_read", read, 0);

    // Countdown loop.
    load_begin();
    prog[0]  = 16'h000A;  // LDA 10
    prog[1]  = 16'h300B;  // SUB 11
    prog[2]  = 16'h100C;  // STA 12
    prog[3]  = 16'h6001;  // JNE 1
    prog[4]  = 16'h7000;  // STP
    prog[10] = 16'h0003;
    prog[11] = 16'h0001;
    prog[12] = 16'hBEEF;
    settle();
    wr0 = wr_cnt;
    f0  = fetch1_cnt;
    @(negedge clk);
    release_rst();
    run_to_halt(200, n);
    check("cd_cycles", n, 26);
    check("cd_mem12", mem[12], 16'h0000);
    check("cd_fetch1", fetch1_cnt - f0, 3);
    check("cd_writes", wr_cnt - wr0, 3);
    check("cd_pc", dut.pc, 5);

    // ADD overflow and JGE behaviour.
    load_begin();
    prog[0]  = 16'h0014;  // LDA 20
    prog[1]  = 16'h2015;  // ADD 21
    prog[2]  = 16'h1016;  // STA 22
    prog[3]  = 16'h5006;  // JGE 6 (ACC=8000, not taken)
    prog[4]  = 16'h0017;  // LDA 23 (=0)
    prog[5]  = 16'h5007;  // JGE 7 (ACC=0, taken)
    prog[6]  = 16'h7000;  // STP (skipped)
    prog[7]  = 16'h1018;  // STA 24
    prog[8]  = 16'h7000;  // STP
    prog[20] = 16'h7FFF;
    prog[21] = 16'h0001;
    prog[23] = 16'h0000;
    prog[24] = 16'hFFFF;
    settle();
    release_rst();
    run_to_halt(200, n);
    check("ovf_mem22", mem[22], 16'h8000);
    check("ovf_mem24", mem[24], 16'h0000);
    check("ovf_pc", dut.pc, 9);
    check("ovf_cycles", n, 19);

    // Bus timing of LDA 0x0FF.
    load_begin();
    prog[0]     = 16'h00FF;
    prog[1]     = 16'h7000;
    prog[12'hFF] = 16'h1234;
    settle();
    release_rst();
    check("bus_fetch_addr", address, 12'h000);
    check("bus_fetch_read", read, 1);
    @(negedge clk);
    check("bus_ex1_addr", address, 12'h0FF);
    check("bus_ex1_read", read, 1);
    check("bus_ex1_write", write, 0);
    @(negedge clk);
    check("bus_ex2_acc_old", dut.acc, 16'h0000);
    @(negedge clk);
    check("bus_acc_new", writedata, 16'h1234);

    // Reset during ADD EXEC2, then full restart.
    load_begin();
    prog[0]  = 16'h001E;  // LDA 30
    prog[1]  = 16'h201F;  // ADD 31
    prog[2]  = 16'h1020;  // STA 32
    prog[3]  = 16'h7000;  // STP
    prog[30] = 16'h0005;
    prog[31] = 16'h0006;
    prog[32] = 16'hFFFF;
    settle();
    release_rst();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_pre_acc", dut.acc, 16'h0005);
    rst = 1'b0;
    #1;
    check("mid_running", running, 0);
    check("mid_read", read, 0);
    check("mid_write", write, 0);
    check("mid_address", address, 0);
    check("mid_writedata", writedata, 0);
    check("mid_pc", dut.pc, 0);
    settle();
    release_rst();
    run_to_halt(200, n);
    check("mid_restart_cycles", n, 10);
    check("mid_mem32", mem[32], 16'h000B);

    // Reserved opcode 0xA123.
    load_begin();
    prog[0] = 16'h0005;  // LDA 5
    prog[1] = 16'hA123;
    prog[2] = 16'h7000;  // STP
    prog[5] = 16'h4321;
    settle();
    release_rst();
    run_to_halt(200, n);
    check("ill_acc", dut.acc, 16'h4321);
`ifdef MU0_HALT_ON_ILLEGAL_EN
    check("ill_cycles", n, 5);
    check("ill_pc", dut.pc, 2);
`else
    check("ill_cycles", n, 7);
    check("ill_pc", dut.pc, 3);
`endif

    check("rd_wr_clash", clash_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
